// File: rtl/ttl_xcvr_reg.sv
// rtl/ttl_xcvr_reg.sv - clocked bidirectional transceiver with dead-time turnaround FSM
// Optional capture registers are built when TTL_XCVR_REGS_EN is defined.
module ttl_xcvr_reg #(
    parameter int WIDTH = 8,
    parameter int TURN  = 1
) (
    input  logic             clk,
    input  logic             reset,
    inout  wire [WIDTH-1:0]  a,
    inout  wire [WIDTH-1:0]  b,
    input  logic             t_n,
    input  logic             r_n,
    input  logic             cab,
    input  logic             cba,
    input  logic             sab,
    input  logic             sba,
    output logic             oe_a,
    output logic             oe_b,
    output logic             busy,
    output logic             conflict
);

    typedef enum logic [1:0] {ST_IDLE, ST_DRV_AB, ST_DRV_BA, ST_TURN} state_t;
    typedef enum logic [1:0] {REQ_NONE, REQ_AB, REQ_BA} req_t;

    localparam logic [3:0] TURN_LOAD = (TURN > 0) ? 4'(TURN - 1) : 4'd0;

    state_t     state, state_nxt, target;
    req_t       req;
    logic [3:0] cnt, cnt_nxt;

    // Both requests low decodes as NONE so a conflict always releases the bus.
    always_comb begin
        req = REQ_NONE;
        if (!t_n && r_n)
            req = REQ_AB;
        else if (!r_n && t_n)
            req = REQ_BA;
    end

    always_comb begin
        target = ST_IDLE;
        case (req)
            REQ_AB:  target = ST_DRV_AB;
            REQ_BA:  target = ST_DRV_BA;
            default: target = ST_IDLE;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: state_nxt = target;
            ST_DRV_AB, ST_DRV_BA: begin
                if (target != state) begin
                    if (TURN > 0) begin
                        state_nxt = ST_TURN;
                        cnt_nxt   = TURN_LOAD;
                    end else begin
                        state_nxt = target;
                    end
                end
            end
            ST_TURN: begin
                if (cnt != 4'd0)
                    cnt_nxt = cnt - 4'd1;
                else
                    state_nxt = target;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            conflict <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            conflict <= !t_n && !r_n;
        end
    end

    // Enables come straight from the state register, never from the request pins.
    assign oe_a = (state == ST_DRV_BA);
    assign oe_b = (state == ST_DRV_AB);
    assign busy = (state == ST_TURN);

`ifdef TTL_XCVR_REGS_EN
    logic [WIDTH-1:0] reg_ab, reg_ba;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_ab <= '0;
            reg_ba <= '0;
        end else begin
            if (cab)
                reg_ab <= a;
            if (cba)
                reg_ba <= b;
        end
    end

    assign b = oe_b ? (sab ? reg_ab : a) : 'z;
    assign a = oe_a ? (sba ? reg_ba : b) : 'z;
`else
    logic unused_regs;
    assign unused_regs = ^{cab, cba, sab, sba};

    assign b = oe_b ? a : 'z;
    assign a = oe_a ? b : 'z;
`endif

endmodule

// File: tb/tb_ttl_xcvr_reg.sv
// tb/tb_ttl_xcvr_reg.sv - directed bench for ttl_xcvr_reg with TURN=3 and TURN=0 instances
module tb_ttl_xcvr_reg;

`ifdef TTL_XCVR_REGS_EN
    localparam bit REGS = 1'b1;
`else
    localparam bit REGS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       t_n, r_n, cab, cba, sab, sba;
    logic [7:0] drv_a, drv_b;
    logic       en_a, en_b;
    logic [7:0] exp_b;

    wire  [7:0] a3, b3, a0, b0;
    logic       oe_a3, oe_b3, busy3, conflict3;
    logic       oe_a0, oe_b0, busy0, conflict0;

    int checks = 0;
    int errors = 0;

    assign a3 = en_a ? drv_a : 'z;
    assign b3 = en_b ? drv_b : 'z;
    assign a0 = en_a ? drv_a : 'z;
    assign b0 = en_b ? drv_b : 'z;

    always #5 clk = ~clk;

    ttl_xcvr_reg #(.WIDTH(8), .TURN(3)) u_t3 (
        .clk(clk), .reset(reset), .a(a3), .b(b3), .t_n(t_n), .r_n(r_n),
        .cab(cab), .cba(cba), .sab(sab), .sba(sba),
        .oe_a(oe_a3), .oe_b(oe_b3), .busy(busy3), .conflict(conflict3)
    );

    ttl_xcvr_reg #(.WIDTH(8), .TURN(0)) u_t0 (
        .clk(clk), .reset(reset), .a(a0), .b(b0), .t_n(t_n), .r_n(r_n),
        .cab(cab), .cba(cba), .sab(sab), .sba(sba),
        .oe_a(oe_a0), .oe_b(oe_b0), .busy(busy0), .conflict(conflict0)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        t_n = 1'b1; r_n = 1'b1;
        cab = 1'b0; cba = 1'b0; sab = 1'b0; sba = 1'b0;
        drv_a = 8'h00; drv_b = 8'h00; en_a = 1'b0; en_b = 1'b0;
        tick;
        tick;
        chk("rst_oe_a", oe_a3, 0);
        chk("rst_oe_b", oe_b3, 0);
        chk("rst_busy", busy3, 0);
        chk("rst_conflict", conflict3, 0);
        reset = 1'b0;

        // A onto B: one cycle from request to enable, live data
        t_n = 1'b0; drv_a = 8'hA5; en_a = 1'b1;
        #1;
        chk("ab_pre_edge_oe_b", oe_b3, 0);
        tick;
        chk("ab_oe_b", oe_b3, 1);
        chk("ab_oe_a", oe_a3, 0);
        chk("ab_b", b3, 8'hA5);
        chk("ab_t0_b", b0, 8'hA5);
        drv_a = 8'h5C;
        #1;
        chk("ab_live_b", b3, 8'h5C);

        // Reversal to B onto A: TURN=3 floats 3 cycles, TURN=0 swaps on the edge
        en_a = 1'b0; t_n = 1'b1; r_n = 1'b0;
        tick;
        chk("t0_swap_oe_b", oe_b0, 0);
        chk("t0_swap_oe_a", oe_a0, 1);
        en_b = 1'b1; drv_b = 8'h3C;
        #1;
        chk("t0_a_follows", a0, 8'h3C);
        for (int i = 0; i < 3; i++) begin
            chk("rev_busy", busy3, 1);
            chk("rev_float", {oe_a3, oe_b3}, 2'b00);
            tick;
        end
        chk("rev_busy_done", busy3, 0);
        chk("rev_oe_a", oe_a3, 1);
        chk("rev_a", a3, 8'h3C);

        // Release: enable drops one cycle after the request goes away
        r_n = 1'b1;
        tick;
        chk("rel_oe_a", oe_a3, 0);
        chk("rel_busy", busy3, 1);
        chk("rel_t0_oe_a", oe_a0, 0);
        chk("rel_t0_busy", busy0, 0);
        tick; tick; tick;
        chk("rel_idle", busy3, 0);

        // Conflict held two edges from DRV_AB
        en_b = 1'b0; en_a = 1'b1; drv_a = 8'h11; t_n = 1'b0;
        tick;
        chk("cf_start_oe_b", oe_b3, 1);
        r_n = 1'b0;
        tick;
        chk("cf_pulse1", conflict3, 1);
        chk("cf_busy", busy3, 1);
        chk("cf_float", {oe_a3, oe_b3}, 2'b00);
        chk("cf_t0_float", {oe_a0, oe_b0, busy0}, 3'b000);
        tick;
        chk("cf_pulse2", conflict3, 1);
        t_n = 1'b1; r_n = 1'b1;
        tick;
        chk("cf_clear", conflict3, 0);
        tick;
        chk("cf_idle", {oe_a3, oe_b3, busy3}, 3'b000);

        // Capture A then drive B from the register
        drv_a = 8'h5A; cab = 1'b1;
        tick;
        cab = 1'b0; drv_a = 8'hFF; sab = 1'b1; t_n = 1'b0;
        tick;
        exp_b = REGS ? 8'h5A : 8'hFF;
        chk("reg_b", b3, exp_b);
        chk("reg_t0_b", b0, exp_b);

        // Async reset in DRV_BA
        en_a = 1'b0; t_n = 1'b1; r_n = 1'b0; sab = 1'b0;
        tick;
        en_b = 1'b1; drv_b = 8'h77;
        tick; tick; tick;
        chk("ba_oe_a", oe_a3, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_oe_a", oe_a3, 0);
        chk("async_t0_oe_a", oe_a0, 0);
        chk("async_busy", busy3, 0);
        tick;
        en_b = 1'b0; r_n = 1'b1; t_n = 1'b0; sab = 1'b1; en_a = 1'b1; drv_a = 8'hC3;
        reset = 1'b0;
        tick;
        chk("post_rst_oe_b", oe_b3, 1);
        exp_b = REGS ? 8'h00 : 8'hC3;
        chk("post_rst_reg_b", b3, exp_b);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
